// File: rtl/y_frame_deserializer.sv
// y_frame_deserializer: reassembles the 82-bit y bus from CHUNK_W-bit valid/ready chunks, splits its fields and flags invariant/framing errors
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_data/in_last chunk stream (LSB-first);
//        out_valid/out_ready frame handshake; frame_word y[81:0]; f_w9..f_w5 packed fields;
//        inv_err structural invariant violation; frame_err misplaced or missing in_last.
module y_frame_deserializer #(
  parameter int CHUNK_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CHUNK_W-1:0] in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [81:0]        frame_word,
  output logic [17:0]        f_w9,
  output logic [10:0]        f_w8,
  output logic [17:0]        f_w7,
  output logic [21:0]        f_w6,
  output logic [11:0]        f_w5,
  output logic               inv_err,
  output logic               frame_err
);
  localparam int NCHUNK = (82 + CHUNK_W - 1) / CHUNK_W;
  localparam int CW = $clog2(NCHUNK + 1);
  localparam int W = NCHUNK * CHUNK_W;
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt;
  logic [81:0] acc;
  logic [81:0] placed;
  logic take, last_idx, close;
  assign in_ready = state != HOLD;
  assign out_valid = state == HOLD;
  assign take = in_valid && in_ready;
  assign last_idx = cnt == CW'(NCHUNK - 1);
  assign close = take && (last_idx || in_last);
  // pad bits shifted above y[81] fall off in the truncation
  assign placed = 82'(W'(in_data) << (32'(cnt) * CHUNK_W));
  always_comb begin
    state_d = state;
    if (state == HOLD) state_d = out_ready ? IDLE : HOLD;
    else state_d = close ? HOLD : take ? COLLECT : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;
  // acc is cleared on close so an early in_last leaves unreceived bits at 0
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      frame_word <= '0;
      frame_err <= 1'b0;
    end else if (close) begin
      cnt <= '0;
      acc <= '0;
      frame_word <= acc | placed;
      frame_err <= in_last ^ last_idx;
    end else if (take) begin
      cnt <= cnt + 1'b1;
      acc <= acc | placed;
    end
  assign f_w9 = frame_word[81:64];
  assign f_w8 = frame_word[63:53];
  assign f_w7 = frame_word[52:35];
  assign f_w6 = frame_word[34:13];
  assign f_w5 = frame_word[12:1];
  assign inv_err = out_valid && (frame_word[0] || (f_w5[11:5] != '0) ||
                   (f_w8 != {10'b0, f_w5 == '0}) || (f_w9 != {16'b0, f_w5[4:3]}) ||
                   ((f_w7 != {16'b0, f_w5[3:2]}) && (f_w7 != {17'b0, f_w5[3]})));
endmodule

// File: tb/tb_y_frame_deserializer.sv
// tb_y_frame_deserializer: directed bench for y_frame_deserializer at CHUNK_W=8, 5 and 82
module tb_y_frame_deserializer;
  logic clk = 1'b0;
  logic rst, in_last, out_ready;
  logic v8, v5, v82;
  logic [7:0] d8;
  logic [4:0] d5;
  logic [81:0] d82;
  logic rdy8, rdy5, rdy82, ov8, ov5, ov82;
  logic [81:0] fw8, fw5, fw82;
  logic [17:0] a9, b9, c9, a7, b7, c7;
  logic [10:0] a8, b8, c8;
  logic [21:0] a6, b6, c6;
  logic [11:0] a5, b5, c5;
  logic ie8, ie5, ie82, fe8, fe5, fe82;
  int n_cmp = 0;
  int n_err = 0;
  logic [81:0] y1, y2, y3, y4, y5, y6, yp, snap;
  always #5 clk = ~clk;
  y_frame_deserializer #(.CHUNK_W(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in_data(d8), .in_last(in_last),
    .out_valid(ov8), .out_ready(out_ready), .frame_word(fw8), .f_w9(a9), .f_w8(a8),
    .f_w7(a7), .f_w6(a6), .f_w5(a5), .inv_err(ie8), .frame_err(fe8));
  y_frame_deserializer #(.CHUNK_W(5)) u5 (
    .clk(clk), .rst(rst), .in_valid(v5), .in_ready(rdy5), .in_data(d5), .in_last(in_last),
    .out_valid(ov5), .out_ready(out_ready), .frame_word(fw5), .f_w9(b9), .f_w8(b8),
    .f_w7(b7), .f_w6(b6), .f_w5(b5), .inv_err(ie5), .frame_err(fe5));
  y_frame_deserializer #(.CHUNK_W(82)) u82 (
    .clk(clk), .rst(rst), .in_valid(v82), .in_ready(rdy82), .in_data(d82), .in_last(in_last),
    .out_valid(ov82), .out_ready(out_ready), .frame_word(fw82), .f_w9(c9), .f_w8(c8),
    .f_w7(c7), .f_w6(c6), .f_w5(c5), .inv_err(ie82), .frame_err(fe82));
  function automatic logic [81:0] mk(input logic [17:0] w9, input logic [10:0] w8,
      input logic [17:0] w7, input logic [21:0] w6, input logic [11:0] w5, input logic b0);
    return {w9, w8, w7, w6, w5, b0};
  endfunction
  task automatic chk(input string tag, input logic [81:0] obs, input logic [81:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  // bits above y[81] are driven as ones so pad handling is exercised
  task automatic send(input int which, input logic [81:0] y, input int n, input int lastk);
    logic [169:0] ext;
    ext = {{88{1'b1}}, y};
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_last = (k == lastk);
      case (which)
        0: begin v8 = 1'b1; d8 = 8'(ext >> (k * 8)); end
        1: begin v5 = 1'b1; d5 = 5'(ext >> (k * 5)); end
        default: begin v82 = 1'b1; d82 = 82'(ext >> (k * 82)); end
      endcase
      @(posedge clk);
    end
    @(negedge clk);
    v8 = 1'b0; v5 = 1'b0; v82 = 1'b0; in_last = 1'b0;
  endtask
  task automatic consume;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask
  initial begin
    rst = 1'b1; in_last = 1'b0; out_ready = 1'b0;
    v8 = 1'b0; v5 = 1'b0; v82 = 1'b0; d8 = '0; d5 = '0; d82 = '0;
    y1 = mk(18'h3, 11'h0, 18'h3, 22'h2ABCDE, 12'h01C, 1'b0);
    y2 = mk(18'h3, 11'h0, 18'h1, 22'h2ABCDE, 12'h01C, 1'b0);
    y3 = mk(18'h3, 11'h0, 18'h2, 22'h2ABCDE, 12'h01C, 1'b0);
    y4 = mk(18'h0, 11'h001, 18'h0, 22'h0, 12'h0, 1'b0);
    y5 = mk(18'h0, 11'h000, 18'h0, 22'h0, 12'h0, 1'b0);
    y6 = mk(18'h0, 11'h001, 18'h0, 22'h0, 12'h0, 1'b1);
    @(negedge clk);
    chk("rst_in_ready", rdy8, 1);
    chk("rst_out_valid", ov8, 0);
    chk("rst_word", fw8, 0);
    chk("rst_inv_err", ie8, 0);
    chk("rst_frame_err", fe8, 0);
    rst = 1'b0;
    send(0, y1, 11, 10);
    chk("t1_out_valid", ov8, 1);
    chk("t1_word", fw8, y1);
    chk("t1_f_w9", a9, 18'h3);
    chk("t1_f_w8", a8, 11'h0);
    chk("t1_f_w7", a7, 18'h3);
    chk("t1_f_w6", a6, 22'h2ABCDE);
    chk("t1_f_w5", a5, 12'h01C);
    chk("t1_inv_err", ie8, 0);
    chk("t1_frame_err", fe8, 0);
    chk("t1_in_ready", rdy8, 0);
    consume();
    chk("t1_consumed", ov8, 0);
    chk("t1_inv_idle", ie8, 0);
    send(0, y2, 11, 10);
    chk("t2a_inv_err", ie8, 0);
    consume();
    send(0, y3, 11, 10);
    chk("t2b_word", fw8, y3);
    chk("t2b_inv_err", ie8, 1);
    consume();
    send(0, y4, 11, 10);
    chk("t3a_inv_err", ie8, 0);
    consume();
    send(0, y5, 11, 10);
    chk("t3b_inv_err", ie8, 1);
    consume();
    send(0, y6, 11, 10);
    chk("t3c_inv_err", ie8, 1);
    consume();
    send(0, y1, 5, 4);
    yp = y1;
    yp[81:40] = '0;
    chk("t4_out_valid", ov8, 1);
    chk("t4_word", fw8, yp);
    chk("t4_frame_err", fe8, 1);
    consume();
    send(0, y1, 11, 10);
    chk("t4_clean_word", fw8, y1);
    chk("t4_clean_frame_err", fe8, 0);
    snap = fw8;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t5_in_ready", rdy8, 0);
      chk("t5_out_valid", ov8, 1);
      chk("t5_word", fw8, snap);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("t5_release_valid", ov8, 0);
    chk("t5_release_ready", rdy8, 1);
    send(0, y3, 11, -1);
    chk("nolast_word", fw8, y3);
    chk("nolast_frame_err", fe8, 1);
    consume();
    send(0, y2, 7, -1);
    chk("t6_partial_idle", ov8, 0);
    rst = 1'b1;
    #1;
    chk("t6_rst_word", fw8, 0);
    chk("t6_rst_frame_err", fe8, 0);
    chk("t6_rst_valid", ov8, 0);
    chk("t6_rst_ready", rdy8, 1);
    @(negedge clk);
    rst = 1'b0;
    send(0, y1, 11, 10);
    chk("t6_fresh_word", fw8, y1);
    chk("t6_fresh_frame_err", fe8, 0);
    chk("t6_fresh_inv_err", ie8, 0);
    consume();
    send(2, y1, 1, 0);
    chk("w82_valid", ov82, 1);
    chk("w82_word", fw82, y1);
    chk("w82_frame_err", fe82, 0);
    consume();
    send(2, y3, 1, -1);
    chk("w82_nolast_frame_err", fe82, 1);
    chk("w82_nolast_inv_err", ie82, 1);
    rst = 1'b1;
    #1;
    chk("w82_rst_word", fw82, 0);
    chk("w82_rst_valid", ov82, 0);
    chk("w82_rst_frame_err", fe82, 0);
    @(negedge clk);
    rst = 1'b0;
    send(2, y2, 1, 0);
    chk("w82_fresh_word", fw82, y2);
    chk("w82_fresh_inv_err", ie82, 0);
    consume();
    send(1, y1, 17, 16);
    chk("w5_valid", ov5, 1);
    chk("w5_word", fw5, y1);
    chk("w5_frame_err", fe5, 0);
    consume();
    send(1, y3, 7, -1);
    rst = 1'b1;
    #1;
    chk("w5_rst_word", fw5, 0);
    chk("w5_rst_ready", rdy5, 1);
    @(negedge clk);
    rst = 1'b0;
    send(1, y2, 17, 16);
    chk("w5_fresh_word", fw5, y2);
    chk("w5_fresh_inv_err", ie5, 0);
    chk("w5_fresh_frame_err", fe5, 0);
    consume();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
